// File: rtl/bf_array_core.sv
// Two-beam, NCH-channel I/Q beamformer mixer with double-buffered weights and a 3-stage pipeline.
// Optional build macro BF_DITHER_EN adds LFSR dither on bit 0 of every channel output.
module bf_array_core #(
    parameter int NCH = 8,
    parameter int DW  = 10,
    parameter int WW  = 5,
    localparam int OW = DW + WW + 2,
    localparam int CW = $clog2(NCH)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DW-1:0]       in_i_1,
    input  logic [DW-1:0]       in_q_1,
    input  logic [DW-1:0]       in_i_2,
    input  logic [DW-1:0]       in_q_2,
    input  logic                in_valid,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [CW-1:0]       wr_ch,
    input  logic [1:0]          wr_sel,
    input  logic [WW-1:0]       wr_data,
    input  logic                commit,
    output logic                commit_pending,
    output logic [NCH*OW-1:0]   mix_o,
    output logic                out_valid
);
    // state   | meaning
    // ST_IDLE | no swap outstanding, shadow bank writable
    // ST_PEND | swap requested, waits for the phase-3 sample

    localparam int PW = DW + WW;

    typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;

    state_t state_q, state_d;
    logic   swap;

    logic [WW-1:0]         shadow_q [NCH][4];
    logic [WW-1:0]         active_q [NCH][4];
    logic [1:0]            phase_q, ph1_q, ph2_q;
    logic                  v1_q, v2_q, out_valid_q;
    logic signed [PW-1:0]  prod_q [NCH][8];
    logic signed [OW-1:0]  i_q [NCH];
    logic signed [OW-1:0]  q_q [NCH];
    logic [NCH*OW-1:0]     mix_d, mix_q;

    function automatic logic signed [PW-1:0] mul(input logic [DW-1:0] x, input logic [WW-1:0] w);
        logic signed [PW-1:0] xe, we;
        xe = {{WW{x[DW-1]}}, x};
        we = {{DW{w[WW-1]}}, w};
        return xe * we;
    endfunction

    function automatic logic signed [OW-1:0] sx(input logic signed [PW-1:0] p);
        return {{(OW-PW){p[PW-1]}}, p};
    endfunction

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (commit) state_d = ST_PEND;
            ST_PEND: if (swap)   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        commit_pending = (state_q == ST_PEND);
        wr_ready       = !commit_pending && !reset;
        swap           = commit_pending && in_valid && (phase_q == 2'd3);
    end

    // Swap lands on the phase-3 edge, so that sample still sees the old bank and phase 0 the new.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q <= '0;
            for (int k = 0; k < NCH; k++) begin
                for (int s = 0; s < 4; s++) begin
                    shadow_q[k][s] <= '0;
                    active_q[k][s] <= '0;
                end
            end
        end else begin
            if (wr_valid && wr_ready) shadow_q[wr_ch][wr_sel] <= wr_data;
            if (swap) begin
                for (int k = 0; k < NCH; k++) begin
                    for (int s = 0; s < 4; s++) active_q[k][s] <= shadow_q[k][s];
                end
            end
            if (in_valid) phase_q <= phase_q + 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v1_q  <= 1'b0;
            ph1_q <= '0;
            for (int k = 0; k < NCH; k++) begin
                for (int p = 0; p < 8; p++) prod_q[k][p] <= '0;
            end
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                ph1_q <= phase_q;
                for (int k = 0; k < NCH; k++) begin
                    prod_q[k][0] <= mul(in_i_1, active_q[k][0]);
                    prod_q[k][1] <= mul(in_q_1, active_q[k][1]);
                    prod_q[k][2] <= mul(in_i_2, active_q[k][2]);
                    prod_q[k][3] <= mul(in_q_2, active_q[k][3]);
                    prod_q[k][4] <= mul(in_i_1, active_q[k][1]);
                    prod_q[k][5] <= mul(in_q_1, active_q[k][0]);
                    prod_q[k][6] <= mul(in_i_2, active_q[k][3]);
                    prod_q[k][7] <= mul(in_q_2, active_q[k][2]);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v2_q  <= 1'b0;
            ph2_q <= '0;
            for (int k = 0; k < NCH; k++) begin
                i_q[k] <= '0;
                q_q[k] <= '0;
            end
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                ph2_q <= ph1_q;
                for (int k = 0; k < NCH; k++) begin
                    i_q[k] <= sx(prod_q[k][0]) - sx(prod_q[k][1]) + sx(prod_q[k][2]) - sx(prod_q[k][3]);
                    q_q[k] <= sx(prod_q[k][4]) + sx(prod_q[k][5]) + sx(prod_q[k][6]) + sx(prod_q[k][7]);
                end
            end
        end
    end

`ifdef BF_DITHER_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_ff @(posedge clock) begin
        if (reset)     lfsr_q <= 16'hACE1;
        else if (v2_q) lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
`endif

    always_comb begin
        mix_d = '0;
        for (int k = 0; k < NCH; k++) begin
            case (ph2_q)
                2'd0:    mix_d[k*OW +: OW] = i_q[k];
                2'd1:    mix_d[k*OW +: OW] = q_q[k];
                2'd2:    mix_d[k*OW +: OW] = -i_q[k];
                default: mix_d[k*OW +: OW] = -q_q[k];
            endcase
`ifdef BF_DITHER_EN
            mix_d[k*OW] = mix_d[k*OW] ^ lfsr_q[0];
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mix_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= v2_q;
            if (v2_q) mix_q <= mix_d;
        end
    end

    assign mix_o     = mix_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bf_array_core.sv
// Directed self-checking bench for bf_array_core (default build, no dither).
module tb_bf_array_core;
    localparam int NCH = 8;
    localparam int DW  = 10;
    localparam int WW  = 5;
    localparam int OW  = DW + WW + 2;
    localparam int CW  = $clog2(NCH);

    logic              clock = 1'b0;
    logic              reset;
    logic [DW-1:0]     in_i_1, in_q_1, in_i_2, in_q_2;
    logic              in_valid;
    logic              wr_valid;
    logic              wr_ready;
    logic [CW-1:0]     wr_ch;
    logic [1:0]        wr_sel;
    logic [WW-1:0]     wr_data;
    logic              commit;
    logic              commit_pending;
    logic [NCH*OW-1:0] mix_o;
    logic              out_valid;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint expv [8];

    always #5 clock = ~clock;

    bf_array_core #(.NCH(NCH), .DW(DW), .WW(WW)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_i_1         (in_i_1),
        .in_q_1         (in_q_1),
        .in_i_2         (in_i_2),
        .in_q_2         (in_q_2),
        .in_valid       (in_valid),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_ch          (wr_ch),
        .wr_sel         (wr_sel),
        .wr_data        (wr_data),
        .commit         (commit),
        .commit_pending (commit_pending),
        .mix_o          (mix_o),
        .out_valid      (out_valid)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint chan(input int k);
        return longint'($signed(mix_o[k*OW +: OW]));
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input int i1, input int q1, input int i2, input int q2);
        in_i_1 = i1[DW-1:0];
        in_q_1 = q1[DW-1:0];
        in_i_2 = i2[DW-1:0];
        in_q_2 = q2[DW-1:0];
    endtask

    task automatic wr(input int ch, input int sel, input int data);
        wr_valid = 1'b1;
        wr_ch    = ch[CW-1:0];
        wr_sel   = sel[1:0];
        wr_data  = data[WW-1:0];
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic set_exp(input longint e0, input longint e1, input longint e2, input longint e3,
                           input longint e4, input longint e5, input longint e6, input longint e7);
        expv[0] = e0; expv[1] = e1; expv[2] = e2; expv[3] = e3;
        expv[4] = e4; expv[5] = e5; expv[6] = e6; expv[7] = e7;
    endtask

    // Eight back-to-back samples; sample t appears on mix_o after the edge of loop step t+2.
    task automatic run_stream(input string tag, input int ch, input int cm_at, input logic [15:0] pmask);
        for (int t = 0; t < 10; t++) begin
            in_valid = (t < 8);
            commit   = (t == cm_at);
            tick();
            commit = 1'b0;
            if (t < 8) begin
                check($sformatf("%s_pend%0d", tag, t), longint'(commit_pending), longint'(pmask[t]));
                check($sformatf("%s_wrrdy%0d", tag, t), longint'(wr_ready), longint'(!pmask[t]));
            end
            if (t >= 2) begin
                check($sformatf("%s_ov%0d", tag, t - 2), longint'(out_valid), 1);
                check($sformatf("%s_ch%0d_s%0d", tag, ch, t - 2), chan(ch), expv[t-2]);
            end
        end
        in_valid = 1'b0;
        tick();
        check({tag, "_ov_end"}, longint'(out_valid), 0);
        check({tag, "_hold"}, chan(ch), expv[7]);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        wr_valid = 1'b0;
        wr_ch    = '0;
        wr_sel   = '0;
        wr_data  = '0;
        commit   = 1'b0;
        set_in(0, 0, 0, 0);
        tick();
        tick();
        check("rst_ov", longint'(out_valid), 0);
        check("rst_mix_nz", longint'(|mix_o), 0);
        check("rst_pend", longint'(commit_pending), 0);
        check("rst_wrrdy", longint'(wr_ready), 0);
        reset = 1'b0;
        #1;
        check("post_rst_wrrdy", longint'(wr_ready), 1);

        // ch0 cos1 = 1, i1 = 100: 100, 0, -100, 0 once the swap has taken effect
        wr(0, 0, 1);
        do_commit();
        set_in(100, 0, 0, 0);
        set_exp(0, 0, 0, 0, 100, 0, -100, 0);
        run_stream("t1", 0, -1, 16'h0007);
        check("t1_ch1_zero", chan(1), 0);
        check("t1_ch3_zero", chan(3), 0);

        // ch3 all weights -16, all inputs -512: I = 0, Q = 32768
        wr(3, 0, -16);
        wr(3, 1, -16);
        wr(3, 2, -16);
        wr(3, 3, -16);
        do_commit();
        set_in(-512, -512, -512, -512);
        set_exp(0, 0, 0, 0, 0, 32768, 0, -32768);
        run_stream("t2", 3, -1, 16'h0007);

        // commit raised together with the phase-1 sample
        wr(1, 0, 2);
        set_in(10, 0, 0, 0);
        set_exp(0, 0, 0, 0, 20, 0, -20, 0);
        run_stream("t3", 1, 1, 16'h0006);

        // commit with no samples: stays pending, writes refused
        commit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t4_pend%0d", i), longint'(commit_pending), 1);
            check($sformatf("t4_wrrdy%0d", i), longint'(wr_ready), 0);
            check($sformatf("t4_ov%0d", i), longint'(out_valid), 0);
        end
        commit = 1'b0;
        wr(2, 0, 7);
        check("t4_pend_after_wr", longint'(commit_pending), 1);
        set_exp(0, 0, 0, 0, 0, 0, 0, 0);
        run_stream("t4", 2, -1, 16'h0007);

        // reset with two samples in flight and a commit pending
        check("t5_mix_before", chan(3), 160);
        do_commit();
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        check("t5_ov", longint'(out_valid), 0);
        check("t5_mix_nz", longint'(|mix_o), 0);
        check("t5_pend", longint'(commit_pending), 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t5_flush_ov%0d", i), longint'(out_valid), 0);
        end
        set_exp(0, 0, 0, 0, 0, 0, 0, 0);
        run_stream("t5", 3, -1, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
